// File: rtl/rst_ctrl_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding, parameter defaults
// and the counter-width helper.
package rst_ctrl_pkg;

    typedef enum logic [1:0] {
        StHold    = 2'd0,
        StRelease = 2'd1,
        StRun     = 2'd2
    } seq_state_e;

    localparam int unsigned DefPinNum     = 2;
    localparam int unsigned DefDebCycles  = 750000;
    localparam int unsigned DefNumStages  = 2;
    localparam int unsigned DefHoldCycles = 64;
    localparam int unsigned DefStageGap   = 16;
    localparam int unsigned DefLongCycles = 150000000;

    // One spare bit so a counter never wraps before its terminal compare.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/deb_chan.sv
// One input channel: 2-flop synchronizer, stable-count debounce and edge pulses.
// pin_out follows the synchronized level after DEB_CYCLES consecutive disagreeing cycles.
module deb_chan
    import rst_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DefDebCycles
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_in,
    output logic pin_out,
    output logic pin_rise,
    output logic pin_fall
);

    localparam int unsigned CntW = cnt_width(DEB_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES - 1);

    logic [1:0]      sync_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            out_q, out_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;
    logic            level;

    assign level = sync_q[1];

    always_comb begin
        cnt_d  = '0;
        out_d  = out_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (level != out_q) begin
            if (cnt_q == CntMax) begin
                out_d  = level;
                rise_d = level;
                fall_d = ~level;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            out_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], pin_in};
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign pin_out  = out_q;
    assign pin_rise = rise_q;
    assign pin_fall = fall_q;

endmodule

// File: rtl/reset_seq_ctrl.sv
// Reset sequencer: lock detect, soft request and debounced pins hold all stages in reset,
// then release them one by one. Define LONG_PRESS_EN for the channel-0 long-press feature.
module reset_seq_ctrl
    import rst_ctrl_pkg::*;
#(
    parameter int unsigned PIN_NUM     = DefPinNum,
    parameter int unsigned DEB_CYCLES  = DefDebCycles,
    parameter int unsigned NUM_STAGES  = DefNumStages,
    parameter int unsigned HOLD_CYCLES = DefHoldCycles,
    parameter int unsigned STAGE_GAP   = DefStageGap,
    parameter int unsigned LONG_CYCLES = DefLongCycles
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  locked,
    input  logic                  rst_req,
    input  logic [PIN_NUM-1:0]    pin_in,
    input  logic [PIN_NUM-1:0]    rst_src_en,
    output logic [PIN_NUM-1:0]    pin_out,
    output logic [PIN_NUM-1:0]    pin_rise,
    output logic [PIN_NUM-1:0]    pin_fall,
    output logic [NUM_STAGES-1:0] stage_rst,
    output logic                  seq_done,
    output logic                  long_press
);

    localparam int unsigned HoldW = cnt_width(HOLD_CYCLES);
    localparam int unsigned GapW  = cnt_width(STAGE_GAP);
    localparam int unsigned IdxW  = cnt_width(NUM_STAGES);
    localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_CYCLES - 1);
    localparam logic [GapW-1:0]  GapMax  = GapW'(STAGE_GAP - 1);
    localparam logic [IdxW-1:0]  IdxLast = IdxW'(NUM_STAGES - 1);

    if (PIN_NUM < 1 || PIN_NUM > 8 || NUM_STAGES < 1 || NUM_STAGES > 4 || DEB_CYCLES < 1 ||
        HOLD_CYCLES < 1 || STAGE_GAP < 1 || LONG_CYCLES < 1) begin : g_param_err
        $error("reset_seq_ctrl: parameter out of range");
    end

    logic [1:0] lock_sync_q;
    logic       src;
    logic       lp_src;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_sync_q <= '0;
        end else begin
            lock_sync_q <= {lock_sync_q[0], locked};
        end
    end

    for (genvar i = 0; i < PIN_NUM; i++) begin : g_chan
        deb_chan #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb_chan (
            .clk     (clk),
            .rst     (rst),
            .pin_in  (pin_in[i]),
            .pin_out (pin_out[i]),
            .pin_rise(pin_rise[i]),
            .pin_fall(pin_fall[i])
        );
    end

`ifdef LONG_PRESS_EN
    localparam int unsigned LpW = cnt_width(LONG_CYCLES);
    localparam logic [LpW-1:0] LpMax = LpW'(LONG_CYCLES - 1);

    logic [LpW-1:0] lp_cnt_q, lp_cnt_d;
    logic           lp_active_q, lp_active_d;
    logic           lp_pulse_q, lp_pulse_d;

    // Counter saturates once the press is recognised; only the fall of pin_out[0] rearms it.
    always_comb begin
        lp_cnt_d    = '0;
        lp_active_d = 1'b0;
        lp_pulse_d  = 1'b0;
        if (pin_out[0]) begin
            lp_cnt_d    = lp_cnt_q;
            lp_active_d = lp_active_q;
            if (!lp_active_q) begin
                if (lp_cnt_q == LpMax) begin
                    lp_active_d = 1'b1;
                    lp_pulse_d  = 1'b1;
                end else begin
                    lp_cnt_d = lp_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lp_cnt_q    <= '0;
            lp_active_q <= 1'b0;
            lp_pulse_q  <= 1'b0;
        end else begin
            lp_cnt_q    <= lp_cnt_d;
            lp_active_q <= lp_active_d;
            lp_pulse_q  <= lp_pulse_d;
        end
    end

    assign lp_src     = lp_active_q & pin_out[0];
    assign long_press = lp_pulse_q;
`else
    assign lp_src     = 1'b0;
    assign long_press = 1'b0;
`endif

    assign src = ~lock_sync_q[1] | rst_req | (|(pin_out & rst_src_en)) | lp_src;

    seq_state_e            state_q, state_d;
    logic [HoldW-1:0]      hold_cnt_q, hold_cnt_d;
    logic [GapW-1:0]       gap_cnt_q, gap_cnt_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [NUM_STAGES-1:0] stage_q, stage_d;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = '0;
        gap_cnt_d  = '0;
        idx_d      = idx_q;
        if (src) begin
            state_d = StHold;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                StHold: begin
                    idx_d = '0;
                    if (hold_cnt_q == HoldMax) begin
                        state_d = StRelease;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                StRelease: begin
                    if (idx_q == IdxLast) begin
                        state_d = StRun;
                    end else if (gap_cnt_q == GapMax) begin
                        idx_d = idx_q + 1'b1;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
                StRun:   state_d = StRun;
                default: state_d = StHold;
            endcase
        end
    end

    // Stage resets are registered from the next state so they never glitch.
    always_comb begin
        stage_d = '1;
        if (state_d == StRun) begin
            stage_d = '0;
        end else if (state_d == StRelease) begin
            for (int i = 0; i < int'(NUM_STAGES); i++) begin
                stage_d[i] = (i > int'(idx_d));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StHold;
            hold_cnt_q <= '0;
            gap_cnt_q  <= '0;
            idx_q      <= '0;
            stage_q    <= '1;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            idx_q      <= idx_d;
            stage_q    <= stage_d;
        end
    end

    assign stage_rst = stage_q;
    assign seq_done  = (state_q == StRun);

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Scoreboard bench for reset_seq_ctrl: a timeline model predicts every cycle's outputs,
// a separate monitor compares them; reset values are checked whenever rst is high.
module tb_reset_seq_ctrl;

    localparam int unsigned PIN_NUM = 2;
    localparam int unsigned DEB     = 4;
    localparam int unsigned NSTG    = 3;
    localparam int unsigned HOLD    = 8;
    localparam int unsigned GAP     = 3;
    localparam int unsigned LONG    = 20;

    logic                clk = 1'b0;
    logic                rst;
    logic                locked;
    logic                rst_req;
    logic [PIN_NUM-1:0]  pin_in;
    logic [PIN_NUM-1:0]  rst_src_en;
    logic [PIN_NUM-1:0]  pin_out;
    logic [PIN_NUM-1:0]  pin_rise;
    logic [PIN_NUM-1:0]  pin_fall;
    logic [NSTG-1:0]     stage_rst;
    logic                seq_done;
    logic                long_press;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    reset_seq_ctrl #(
        .PIN_NUM    (PIN_NUM),
        .DEB_CYCLES (DEB),
        .NUM_STAGES (NSTG),
        .HOLD_CYCLES(HOLD),
        .STAGE_GAP  (GAP),
        .LONG_CYCLES(LONG)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .locked    (locked),
        .rst_req   (rst_req),
        .pin_in    (pin_in),
        .rst_src_en(rst_src_en),
        .pin_out   (pin_out),
        .pin_rise  (pin_rise),
        .pin_fall  (pin_fall),
        .stage_rst (stage_rst),
        .seq_done  (seq_done),
        .long_press(long_press)
    );

    typedef struct packed {
        logic [PIN_NUM-1:0] out;
        logic [PIN_NUM-1:0] rise;
        logic [PIN_NUM-1:0] fall;
        logic [NSTG-1:0]    stg;
        logic               done;
        logic               lp;
    } obs_t;

    obs_t exp_q[$];

    // Reference model: quiet = consecutive source-free cycles; stage k is out of reset once
    // quiet reaches HOLD + k*GAP, and the sequence is done one cycle after the last stage.
    bit [PIN_NUM-1:0] m_s1, m_s2, m_out;
    int               run [PIN_NUM];
    bit               m_l1, m_l2;
    int               quiet;
    int               hi_time;
    bit               m_lp_src;
    obs_t             e;
    bit               src;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1 = '0;
            m_s2 = '0;
            m_out = '0;
            for (int i = 0; i < PIN_NUM; i++) run[i] = 0;
            m_l1 = 1'b0;
            m_l2 = 1'b0;
            quiet = 0;
            hi_time = 0;
            m_lp_src = 1'b0;
            exp_q.delete();
        end else begin
            src = !m_l2 || rst_req || ((m_out & rst_src_en) != '0) || m_lp_src;
            quiet = src ? 0 : ((quiet < 1000) ? quiet + 1 : quiet);
            hi_time = m_out[0] ? ((hi_time < 1000) ? hi_time + 1 : hi_time) : 0;
            e = '0;
            for (int i = 0; i < PIN_NUM; i++) begin
                if (m_s2[i] != m_out[i]) begin
                    run[i]++;
                    if (run[i] == DEB) begin
                        m_out[i] = m_s2[i];
                        e.rise[i] = m_s2[i];
                        e.fall[i] = !m_s2[i];
                        run[i] = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
`ifdef LONG_PRESS_EN
            e.lp = (hi_time == LONG);
            m_lp_src = m_out[0] && (hi_time >= LONG);
`endif
            m_s2 = m_s1;
            m_s1 = pin_in;
            m_l2 = m_l1;
            m_l1 = locked;
            e.out = m_out;
            for (int k = 0; k < NSTG; k++) e.stg[k] = !(quiet >= HOLD + k * GAP);
            e.done = (quiet >= HOLD + (NSTG - 1) * GAP + 1);
            exp_q.push_back(e);
        end
    end

    obs_t act, expv;

    always begin
        @(negedge clk or posedge rst);
        #1;
        if (rst) begin
            checks++;
            if ({stage_rst, seq_done, pin_out, pin_rise, pin_fall, long_press} !==
                {{NSTG{1'b1}}, 1'b0, {(3 * PIN_NUM){1'b0}}, 1'b0}) begin
                errors++;
                $display("FAIL reset_values t=%0t actual stg=%b done=%b out=%b rise=%b fall=%b lp=%b required stg=all1 others=0",
                         $time, stage_rst, seq_done, pin_out, pin_rise, pin_fall, long_press);
            end
        end else if (exp_q.size() > 0) begin
            expv = exp_q.pop_front();
            act = {pin_out, pin_rise, pin_fall, stage_rst, seq_done, long_press};
            checks++;
            if (act !== expv) begin
                errors++;
                $display("FAIL cycle_outputs t=%0t actual out=%b rise=%b fall=%b stg=%b done=%b lp=%b required out=%b rise=%b fall=%b stg=%b done=%b lp=%b",
                         $time, act.out, act.rise, act.fall, act.stg, act.done, act.lp,
                         expv.out, expv.rise, expv.fall, expv.stg, expv.done, expv.lp);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        locked = 1'b0;
        rst_req = 1'b0;
        pin_in = '0;
        rst_src_en = '0;
        cyc(3);
        #2 rst = 1'b0;
        // Lock arrives: full hold/release sequence.
        cyc(5);
        locked = 1'b1;
        cyc(30);
        // Short glitch on pin 1, then a real press and release.
        pin_in[1] = 1'b1;
        cyc(3);
        pin_in[1] = 1'b0;
        cyc(10);
        pin_in[1] = 1'b1;
        cyc(12);
        pin_in[1] = 1'b0;
        cyc(10);
        // Soft request at start of HOLD and again mid-RELEASE.
        rst_req = 1'b1;
        cyc(1);
        rst_req = 1'b0;
        cyc(10);
        rst_req = 1'b1;
        cyc(1);
        rst_req = 1'b0;
        cyc(25);
        // Pin 0 as enabled reset source.
        rst_src_en = 2'b01;
        pin_in[0] = 1'b1;
        cyc(20);
        pin_in[0] = 1'b0;
        cyc(30);
        // Long press on pin 0 with no pin source enabled.
        rst_src_en = '0;
        pin_in[0] = 1'b1;
        cyc(30);
        pin_in[0] = 1'b0;
        cyc(40);
        // Random traffic.
        repeat (600) begin
            for (int i = 0; i < PIN_NUM; i++) begin
                if ($urandom_range(0, 4) == 0) pin_in[i] = ~pin_in[i];
            end
            rst_req = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 49) == 0) rst_src_en = PIN_NUM'($urandom);
            locked = ($urandom_range(0, 149) != 0);
            cyc(1);
        end
        // Settle into RUN, then reset asynchronously mid-cycle.
        pin_in = '0;
        rst_req = 1'b0;
        locked = 1'b1;
        rst_src_en = '0;
        cyc(40);
        #2 rst = 1'b1;
        cyc(3);
        #2 rst = 1'b0;
        cyc(30);
        cyc(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
